// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-port, synchronous-read dram between the Core instruction
// port (IM_*) and data port (DM_*). Accesses are serialised as a fixed
// IDLE -> ACCESS -> RESP sequence, and the losing or waiting port is held off
// with its stall output. The data port has fixed priority. A streak counter
// caps how many DM grants can be taken back to back while a fetch is
// waiting, so instruction fetch always makes progress.
//
// Ports
//   CLK, RST              clock; synchronous active-low reset
//   IM_req/IM_addr        fetch request, held stable until not stalled
//   IM_rdata/IM_stall     fetched word / fetch stall
//   DM_req/DM_WEN/
//   DM_addr/DM_wdata      data request (1 = write), held stable until done
//   DM_rdata/DM_stall     read word / data stall
//   MEM_addr/MEM_WEN/
//   MEM_wdata/MEM_rdata   dram interface; MEM_rdata is valid one cycle after
//                         the address is presented
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IM_req,
    input  logic [31:0]           IM_addr,
    output logic [DATA_WIDTH-1:0] IM_rdata,
    output logic                  IM_stall,
    input  logic                  DM_req,
    input  logic                  DM_WEN,
    input  logic [31:0]           DM_addr,
    input  logic [DATA_WIDTH-1:0] DM_wdata,
    output logic [DATA_WIDTH-1:0] DM_rdata,
    output logic                  DM_stall,
    output logic [ADDR_WIDTH-1:0] MEM_addr,
    output logic                  MEM_WEN,
    output logic [DATA_WIDTH-1:0] MEM_wdata,
    input  logic [DATA_WIDTH-1:0] MEM_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    sel;       // 0 = IM owns the current access, 1 = DM
    logic [3:0]              streak;    // DM grants taken while a fetch waited
    logic                    wr_q;      // current DM access is a write
    logic [DATA_WIDTH-1:0]   im_q;
    logic [DATA_WIDTH-1:0]   dm_q;

    logic any_req;
    logic streak_full;
    logic dm_wins;
    logic im_resp;
    logic dm_resp;

    assign any_req     = IM_req | DM_req;
    assign streak_full = (streak == 4'(MAX_DM_STREAK));
    // DM keeps priority until it has starved a waiting fetch for the limit.
    assign dm_wins     = DM_req & ~(IM_req & streak_full);
    assign im_resp     = (state == RESP) & ~sel;
    assign dm_resp     = (state == RESP) &  sel;

    // Only the low ADDR_WIDTH address bits reach the dram.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IM_addr[31:ADDR_WIDTH], DM_addr[31:ADDR_WIDTH]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // sel is stable from ACCESS through RESP, so the address naturally
        // holds its ACCESS value during RESP.
        MEM_addr  = sel ? DM_addr[ADDR_WIDTH-1:0] : IM_addr[ADDR_WIDTH-1:0];
        MEM_wdata = DM_wdata;
        MEM_WEN   = RST & (state == ACCESS) & sel & DM_WEN;

        IM_stall  = RST & IM_req & ~im_resp;
        DM_stall  = RST & DM_req & ~dm_resp;

        // Fresh data is forwarded in RESP; otherwise the last word is held.
        IM_rdata  = im_resp ? MEM_rdata : im_q;
        DM_rdata  = (dm_resp & ~wr_q) ? MEM_rdata : dm_q;
    end

    // -------------------------------------------------------------------------
    // Grant, streak and read-data holding registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sel    <= 1'b0;
            streak <= 4'd0;
            wr_q   <= 1'b0;
            im_q   <= '0;
            dm_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                sel <= dm_wins;
                if (dm_wins && IM_req) begin
                    streak <= streak_full ? streak : streak + 4'd1;
                end else begin
                    streak <= 4'd0;
                end
            end
            if (state == ACCESS) begin
                wr_q <= sel & DM_WEN;
            end
            if (im_resp) begin
                im_q <= MEM_rdata;
            end
            if (dm_resp && !wr_q) begin
                dm_q <= MEM_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives both Core ports from per-port operation queues, emulates the dram,
// and compares every cycle against a transaction-level reference: each grant
// occupies a three-cycle window that starts in the cycle it is decided, the
// write lands in the second cycle, and the owner completes in the third.
// Directed sequences cover the worked cases; a randomized run with occasional
// resets follows.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int MAXS = 4;
    localparam int MEMW = 1 << AW;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        int          gap;
    } op_t;

    typedef struct {
        bit          dm;
        int          cyc;
        logic [31:0] data;
    } done_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IM_req;
    logic [31:0]   IM_addr;
    logic [DW-1:0] IM_rdata;
    logic          IM_stall;
    logic          DM_req;
    logic          DM_WEN;
    logic [31:0]   DM_addr;
    logic [DW-1:0] DM_wdata;
    logic [DW-1:0] DM_rdata;
    logic          DM_stall;
    logic [AW-1:0] MEM_addr;
    logic          MEM_WEN;
    logic [DW-1:0] MEM_wdata;
    logic [DW-1:0] MEM_rdata;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .MAX_DM_STREAK (MAXS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IM_req    (IM_req),
        .IM_addr   (IM_addr),
        .IM_rdata  (IM_rdata),
        .IM_stall  (IM_stall),
        .DM_req    (DM_req),
        .DM_WEN    (DM_WEN),
        .DM_addr   (DM_addr),
        .DM_wdata  (DM_wdata),
        .DM_rdata  (DM_rdata),
        .DM_stall  (DM_stall),
        .MEM_addr  (MEM_addr),
        .MEM_WEN   (MEM_WEN),
        .MEM_wdata (MEM_wdata),
        .MEM_rdata (MEM_rdata)
    );

    function automatic logic [31:0] mem_init(int i);
        return (i == 32'h100) ? 32'h2402000A : (32'h5A00_0000 | 32'(i));
    endfunction

    // Synchronous-read dram
    logic        fill;
    logic [31:0] dram [MEMW];

    always @(posedge CLK) begin
        if (fill) begin
            for (int i = 0; i < MEMW; i++) dram[i] <= mem_init(i);
        end else begin
            if (MEM_WEN) dram[MEM_addr] <= MEM_wdata;
            MEM_rdata <= dram[MEM_addr];
        end
    end

    // Checking
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Requesters and reference model state
    op_t         im_ops[$];
    op_t         dm_ops[$];
    done_t       done_log[$];
    logic [31:0] shadow [MEMW];

    logic        rst_val;
    bit          im_done, dm_done;
    int          im_wait, dm_wait;
    int          cyc;

    bit          busy;
    bit          win_dm;
    op_t         win_op;
    int          start;
    int          streak;
    logic [31:0] im_last, dm_last;

    int          im_stall_cnt, wen_cnt;
    logic [31:0] obs_im_rdata, obs_dm_rdata;
    logic [AW-1:0] obs_mem_addr;

    task automatic cycle();
        bit exp_wen, exp_im_done, exp_dm_done, dm_win;
        @(posedge CLK);
        #1;
        RST = rst_val;
        if (im_done) begin void'(im_ops.pop_front()); IM_req = 1'b0; im_done = 1'b0; end
        if (dm_done) begin void'(dm_ops.pop_front()); DM_req = 1'b0; dm_done = 1'b0; end
        if (!IM_req && im_ops.size() > 0) begin
            if (im_wait < im_ops[0].gap) im_wait++;
            else begin IM_req = 1'b1; IM_addr = im_ops[0].addr; im_wait = 0; end
        end
        if (!DM_req && dm_ops.size() > 0) begin
            if (dm_wait < dm_ops[0].gap) dm_wait++;
            else begin
                DM_req = 1'b1; DM_addr = dm_ops[0].addr;
                DM_WEN = dm_ops[0].wen; DM_wdata = dm_ops[0].wdata; dm_wait = 0;
            end
        end
        cyc++;

        @(negedge CLK);
        exp_wen     = RST && busy && cyc == start + 1 && win_dm && win_op.wen;
        exp_im_done = RST && busy && cyc == start + 2 && !win_dm;
        exp_dm_done = RST && busy && cyc == start + 2 &&  win_dm;

        check("im_stall", IM_stall, RST & IM_req & !exp_im_done);
        check("dm_stall", DM_stall, RST & DM_req & !exp_dm_done);
        check("mem_wen", MEM_WEN, exp_wen);
        if (RST && busy && cyc == start + 1) begin
            check("mem_addr", MEM_addr, win_op.addr[AW-1:0]);
            if (win_dm) obs_mem_addr = MEM_addr;
        end
        if (exp_wen) begin
            check("mem_wdata", MEM_wdata, win_op.wdata);
            shadow[win_op.addr[AW-1:0]] = win_op.wdata;
        end
        if (exp_im_done) begin
            im_last = shadow[win_op.addr[AW-1:0]];
            obs_im_rdata = IM_rdata;
            im_done = 1'b1;
            done_log.push_back('{dm: 1'b0, cyc: cyc, data: im_last});
        end
        if (exp_dm_done) begin
            if (!win_op.wen) begin
                dm_last = shadow[win_op.addr[AW-1:0]];
                obs_dm_rdata = DM_rdata;
            end
            dm_done = 1'b1;
            done_log.push_back('{dm: 1'b1, cyc: cyc, data: dm_last});
        end
        if (RST) begin
            check("im_rdata", IM_rdata, im_last);
            check("dm_rdata", DM_rdata, dm_last);
        end
        if (IM_stall) im_stall_cnt++;
        if (MEM_WEN)  wen_cnt++;

        // Decide what the coming edge does.
        if (!RST) begin
            busy = 1'b0; streak = 0; im_last = '0; dm_last = '0;
        end else if (busy) begin
            if (cyc == start + 2) busy = 1'b0;
        end else if (IM_req || DM_req) begin
            dm_win = DM_req && !(IM_req && streak == MAXS);
            if (dm_win) begin
                streak = IM_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                win_op = dm_ops[0];
            end else begin
                streak = 0;
                win_op = im_ops[0];
            end
            win_dm = dm_win;
            busy   = 1'b1;
            start  = cyc;
        end
    endtask

    task automatic run_ops(input int max_cycles, input bit rnd_rst);
        int n = 0;
        while ((im_ops.size() > 0 || dm_ops.size() > 0) && n < max_cycles) begin
            if (rnd_rst) begin
                if (rst_val == 1'b0) rst_val = 1'b1;
                else if ($urandom_range(0, 299) == 0) rst_val = 1'b0;
            end
            cycle();
            n++;
        end
        rst_val = 1'b1;
        check("ops_drained", im_ops.size() + dm_ops.size(), 0);
    endtask

    task automatic clear_obs();
        im_stall_cnt = 0; wen_cnt = 0;
        done_log.delete();
    endtask

    function automatic op_t rand_op(bit is_dm);
        op_t o;
        o.addr  = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
        o.wen   = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
        o.wdata = $urandom();
        o.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        return o;
    endfunction

    initial begin
        int t0;
        bit pat1 [7] = '{1, 1, 1, 1, 0, 1, 1};
        bit pat2 [6] = '{1, 1, 1, 1, 0, 1};

        IM_req = 1'b0; IM_addr = '0;
        DM_req = 1'b0; DM_WEN = 1'b0; DM_addr = '0; DM_wdata = '0;
        RST = 1'b0; rst_val = 1'b0; fill = 1'b1;
        im_done = 0; dm_done = 0; im_wait = 0; dm_wait = 0; cyc = 0;
        busy = 0; win_dm = 0; start = 0; streak = 0;
        win_op = '{addr: '0, wen: 1'b0, wdata: '0, gap: 0};
        im_last = '0; dm_last = '0;
        obs_im_rdata = '0; obs_dm_rdata = '0; obs_mem_addr = '0;
        for (int i = 0; i < MEMW; i++) shadow[i] = mem_init(i);
        clear_obs();

        // Reset state
        cycle();
        fill = 1'b0;
        repeat (2) cycle();
        check("reset_im_rdata", IM_rdata, 32'h0);
        check("reset_dm_rdata", DM_rdata, 32'h0);
        rst_val = 1'b1;
        cycle();

        // Instruction fetch alone
        clear_obs();
        im_ops.push_back('{addr: 32'h100, wen: 1'b0, wdata: '0, gap: 0});
        run_ops(20, 1'b0);
        check("im_only_stall_cycles", im_stall_cnt, 2);
        check("im_only_rdata", obs_im_rdata, 32'h2402000A);
        check("im_only_wen_cycles", wen_cnt, 0);

        // Data write, then read back
        clear_obs();
        dm_ops.push_back('{addr: 32'h40, wen: 1'b1, wdata: 32'hDEADBEEF, gap: 0});
        dm_ops.push_back('{addr: 32'h40, wen: 1'b0, wdata: '0, gap: 0});
        run_ops(20, 1'b0);
        check("dm_wr_wen_cycles", wen_cnt, 1);
        check("dm_rd_after_wr", obs_dm_rdata, 32'hDEADBEEF);

        // Simultaneous requests: DM first, IM three cycles later
        clear_obs();
        t0 = cyc;
        dm_ops.push_back('{addr: 32'h8, wen: 1'b0, wdata: '0, gap: 0});
        im_ops.push_back('{addr: 32'h9, wen: 1'b0, wdata: '0, gap: 0});
        run_ops(20, 1'b0);
        check("simul_done_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("simul_first_dm", done_log[0].dm, 1'b1);
            check("simul_dm_cycle", done_log[0].cyc - t0, 3);
            check("simul_im_cycle", done_log[1].cyc - t0, 6);
        end

        // Starvation limit, twice in a row to show the streak restarts
        clear_obs();
        for (int i = 0; i < 6; i++)
            dm_ops.push_back('{addr: 32'(i + 1), wen: 1'b0, wdata: '0, gap: 0});
        im_ops.push_back('{addr: 32'h20, wen: 1'b0, wdata: '0, gap: 0});
        run_ops(60, 1'b0);
        check("starve1_count", done_log.size(), 7);
        for (int i = 0; i < 7 && i < done_log.size(); i++)
            check($sformatf("starve1_order%0d", i), done_log[i].dm, pat1[i]);

        clear_obs();
        for (int i = 0; i < 5; i++)
            dm_ops.push_back('{addr: 32'(i + 10), wen: 1'b0, wdata: '0, gap: 0});
        im_ops.push_back('{addr: 32'h21, wen: 1'b0, wdata: '0, gap: 0});
        run_ops(60, 1'b0);
        check("starve2_count", done_log.size(), 6);
        for (int i = 0; i < 6 && i < done_log.size(); i++)
            check($sformatf("starve2_order%0d", i), done_log[i].dm, pat2[i]);

        // Reset during the ACCESS cycle of a DM read, then regrant;
        // the address also exercises truncation to AW bits.
        clear_obs();
        dm_ops.push_back('{addr: 32'h0000_0404, wen: 1'b0, wdata: '0, gap: 0});
        cycle();                 // IDLE, grant decided
        rst_val = 1'b0;
        cycle();                 // ACCESS with reset asserted
        cycle();                 // held in reset
        check("rst_dm_rdata", DM_rdata, 32'h0);
        check("rst_dm_stall", DM_stall, 1'b0);
        check("rst_mem_wen", MEM_WEN, 1'b0);
        rst_val = 1'b1;
        run_ops(20, 1'b0);
        check("rst_regrant_count", done_log.size(), 1);
        check("rst_regrant_rdata", obs_dm_rdata, 32'h5A00_0004);
        check("trunc_mem_addr", obs_mem_addr, 10'h004);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            im_ops.push_back(rand_op(1'b0));
            dm_ops.push_back(rand_op(1'b1));
        end
        run_ops(8000, 1'b1);
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
